systolic_skew_feeder: RTL and testbench

- Upstream stage of the N x N systolic array: buffers one A tile (row-major) and one B tile (column-major), then streams them into the array's left edge (in_a lanes) and top edge (in_b lanes) with the diagonal skew the array needs.
- Zero-pads outside the skew window, holds off while the array drains, and pulses done when every PE's accumulator holds its final dot product.

---
 rtl/systolic_pkg.sv | 22 ++
 rtl/systolic_skew_feeder_tile_buffer.sv | 47 ++++
 rtl/systolic_skew_feeder.sv | 112 +++++++++++
 tb/tb_systolic_skew_feeder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared defaults and feeder types for the systolic array and its skew feeder.
package systolic_pkg;

   localparam int unsigned N_DEF          = 4;
   localparam int unsigned DATA_WIDTH_DEF = 8;
   localparam int unsigned ACC_WIDTH_DEF  = 2 * DATA_WIDTH_DEF + $clog2(N_DEF);
   localparam int unsigned FEED_CYCLES    = 3 * N_DEF - 2;
   localparam int unsigned DRAIN_CYCLES   = N_DEF;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      FEED  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } feeder_state_e;

   // Number of skewed feed cycles for an n x n tile.
   function automatic int unsigned feed_cycles(input int unsigned n);
      return 3 * n - 2;
   endfunction

endpackage

// File: rtl/systolic_skew_feeder_tile_buffer.sv
// A/B tile storage: row-wise A writes, column-wise B writes, skewed combinational read at index rd_t.
module tile_buffer #(
   parameter int unsigned N          = systolic_pkg::N_DEF,
   parameter int unsigned DATA_WIDTH = systolic_pkg::DATA_WIDTH_DEF,
   parameter int unsigned IW         = (N > 1) ? $clog2(N) : 1,
   parameter int unsigned TW         = $clog2(3 * N - 2)
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [IW-1:0]           widx,
   input  logic [N*DATA_WIDTH-1:0] a_row,
   input  logic [N*DATA_WIDTH-1:0] b_col,
   input  logic [TW-1:0]           rd_t,
   output logic [N*DATA_WIDTH-1:0] skew_a_c,
   output logic [N*DATA_WIDTH-1:0] skew_b_c
);

   logic [DATA_WIDTH-1:0] a_mem [N][N];
   logic [DATA_WIDTH-1:0] b_mem [N][N];
   int                    k;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int e = 0; e < int'(N); e++) begin
            a_mem[widx][IW'(e)] <= a_row[e*DATA_WIDTH +: DATA_WIDTH];
            b_mem[IW'(e)][widx] <= b_col[e*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Lane i reads element t-i; the beat being written this cycle bypasses the storage.
   always_comb begin
      skew_a_c = '0;
      skew_b_c = '0;
      k        = 0;
      for (int i = 0; i < int'(N); i++) begin
         k = int'(rd_t) - i;
         if (k >= 0 && k < int'(N)) begin
            skew_a_c[i*DATA_WIDTH +: DATA_WIDTH] = (we && widx == IW'(i)) ?
               a_row[k*DATA_WIDTH +: DATA_WIDTH] : a_mem[IW'(i)][IW'(k)];
            skew_b_c[i*DATA_WIDTH +: DATA_WIDTH] = (we && widx == IW'(i)) ?
               b_col[k*DATA_WIDTH +: DATA_WIDTH] : b_mem[IW'(k)][IW'(i)];
         end
      end
   end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Loads one A/B tile, streams it diagonally skewed into the systolic array, drains, then pulses done.
module systolic_skew_feeder
   import systolic_pkg::*;
#(
   parameter int unsigned N          = N_DEF,
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [N*DATA_WIDTH-1:0] load_a_row,
   input  logic [N*DATA_WIDTH-1:0] load_b_col,
   output logic [N*DATA_WIDTH-1:0] feed_a,
   output logic [N*DATA_WIDTH-1:0] feed_b,
   output logic                    busy,
   output logic                    done
);

   localparam int unsigned   IW       = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned   TW       = $clog2(feed_cycles(N));
   localparam int unsigned   W        = N * DATA_WIDTH;
   localparam logic [TW-1:0] T_LAST   = TW'(feed_cycles(N) - 1);
   localparam logic [IW-1:0] CNT_LAST = IW'(N - 1);

   feeder_state_e state, next_state;
   logic [IW-1:0] beat_cnt, drain_cnt;
   logic [TW-1:0] t, rd_t;
   logic [W-1:0]  skew_a, skew_b, feed_a_d, feed_b_d;
   logic          accept, load_ready_d, busy_d, done_d;

   assign accept = load_valid & load_ready;

   tile_buffer #(
      .N          (N),
      .DATA_WIDTH (DATA_WIDTH),
      .IW         (IW),
      .TW         (TW)
   ) u_buf (
      .clk      (clk),
      .we       (accept),
      .widx     (beat_cnt),
      .a_row    (load_a_row),
      .b_col    (load_b_col),
      .rd_t     (rd_t),
      .skew_a_c (skew_a),
      .skew_b_c (skew_b)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= LOAD;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         LOAD:    if (accept && beat_cnt == CNT_LAST) next_state = FEED;
         FEED:    if (t == T_LAST) next_state = DRAIN;
         DRAIN:   if (drain_cnt == CNT_LAST) next_state = DONE;
         DONE:    next_state = LOAD;
         default: next_state = LOAD;
      endcase
   end

   // Next-cycle output values; the skew read looks one step ahead of the registered t.
   always_comb begin
      rd_t         = '0;
      feed_a_d     = '0;
      feed_b_d     = '0;
      load_ready_d = (next_state == LOAD);
      busy_d       = (next_state == FEED) || (next_state == DRAIN);
      done_d       = (next_state == DONE);
      if (state == FEED) rd_t = t + TW'(1);
      if (next_state == FEED) begin
         feed_a_d = skew_a;
         feed_b_d = skew_b;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_cnt   <= '0;
         t          <= '0;
         drain_cnt  <= '0;
         feed_a     <= '0;
         feed_b     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         load_ready <= 1'b1;
      end else begin
         feed_a     <= feed_a_d;
         feed_b     <= feed_b_d;
         busy       <= busy_d;
         done       <= done_d;
         load_ready <= load_ready_d;
         case (state)
            LOAD: begin
               if (accept) beat_cnt <= (beat_cnt == CNT_LAST) ? '0 : beat_cnt + IW'(1);
               t <= '0;
            end
            FEED: begin
               t         <= (t == T_LAST) ? '0 : t + TW'(1);
               drain_cnt <= '0;
            end
            DRAIN: drain_cnt <= (drain_cnt == CNT_LAST) ? '0 : drain_cnt + IW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Scoreboard bench for systolic_skew_feeder with a behavioural systolic array downstream.
module tb_systolic_skew_feeder;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int W  = N * DW;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         load_valid = 1'b0;
   logic         load_ready;
   logic [W-1:0] load_a_row = '0;
   logic [W-1:0] load_b_col = '0;
   logic [W-1:0] feed_a, feed_b;
   logic         busy, done;

   systolic_skew_feeder #(.N(N), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_a_row (load_a_row),
      .load_b_col (load_b_col),
      .feed_a     (feed_a),
      .feed_b     (feed_b),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                    cyc;
      logic [W-1:0]          fa;
      logic [W-1:0]          fb;
      logic                  busy;
      logic                  done;
      logic [N*N-1:0][31:0]  prod;
   } exp_t;

   exp_t       q[$];
   exp_t       e;
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [7:0] ma [N][N];
   logic [7:0] mb [N][N];
   int         acc [N][N];
   logic [7:0] ar [N][N];
   logic [7:0] br [N][N];
   logic [7:0] am_a, am_b;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Behavioural array: A moves right, B moves down, each PE accumulates its inputs.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (rst || done) begin
               acc[i][j] <= 0;
               ar[i][j]  <= '0;
               br[i][j]  <= '0;
            end else begin
               if (j == 0) am_a = feed_a[i*DW +: DW];
               else        am_a = ar[i][j-1];
               if (i == 0) am_b = feed_b[j*DW +: DW];
               else        am_b = br[i-1][j];
               ar[i][j]  <= am_a;
               br[i][j]  <= am_b;
               acc[i][j] <= acc[i][j] + int'(am_a) * int'(am_b);
            end
         end
      end
   end

   // Monitor: pops an expectation whenever the feeder is busy or signalling done.
   always @(negedge clk) begin
      if (!rst) begin
         if (busy || done) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output cycle %0d: busy=%0b done=%0b, expected idle", cyc, busy, done);
            end else begin
               e = q.pop_front();
               chk("cycle", 64'(cyc), 64'(e.cyc));
               chk("feed_a", 64'(feed_a), 64'(e.fa));
               chk("feed_b", 64'(feed_b), 64'(e.fb));
               chk("busy", 64'(busy), 64'(e.busy));
               chk("done", 64'(done), 64'(e.done));
               chk("load_ready_blocked", 64'(load_ready), 64'(0));
               if (e.done) begin
                  for (int i = 0; i < N; i++)
                     for (int j = 0; j < N; j++)
                        chk("array_result", 64'(acc[i][j]), 64'(e.prod[i*N+j]));
               end
            end
         end else begin
            chk("idle_feed", 64'({feed_a, feed_b}), 64'(0));
            chk("idle_ready", 64'(load_ready), 64'(1));
         end
      end
   end

   // Expected outputs for cycles last+1 .. last+4N-1 of the tile currently in ma/mb.
   task automatic push_tile(input int last);
      exp_t ne;
      logic [N*N-1:0][31:0] p;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            p[i*N+j] = 0;
            for (int k = 0; k < N; k++) p[i*N+j] += 32'(ma[i][k]) * 32'(mb[k][j]);
         end
      for (int s = 1; s <= 4*N-1; s++) begin
         int tt = s - 1;
         ne.cyc  = last + s;
         ne.fa   = '0;
         ne.fb   = '0;
         ne.busy = (s <= 4*N-2);
         ne.done = (s == 4*N-1);
         ne.prod = p;
         if (tt <= 3*N-3) begin
            for (int l = 0; l < N; l++) begin
               if (tt - l >= 0 && tt - l < N) begin
                  ne.fa[l*DW +: DW] = ma[l][tt-l];
                  ne.fb[l*DW +: DW] = mb[tt-l][l];
               end
            end
         end
         q.push_back(ne);
      end
   endtask

   // Drives one cycle per pattern bit (LSB first); a 1 presents the next beat.
   task automatic drive_tile(input logic [6:0] pat, input int plen);
      int beat = 0;
      int last = 0;
      for (int p = 0; p < plen; p++) begin
         @(posedge clk);
         #1;
         if (pat[p]) begin
            load_valid = 1'b1;
            for (int c = 0; c < N; c++) begin
               load_a_row[c*DW +: DW] = ma[beat][c];
               load_b_col[c*DW +: DW] = mb[c][beat];
            end
            beat++;
            last = cyc;
         end else begin
            load_valid = 1'b0;
            load_a_row = W'($urandom);
            load_b_col = W'($urandom);
         end
      end
      push_tile(last);
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 60 && q.size() != 0; k++) @(posedge clk);
      #1;
      chk("queue_drained", 64'(q.size()), 64'(0));
      q.delete();
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic set_a(input int base);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) ma[i][j] = 8'(base + N*i + j);
   endtask

   task automatic set_b(input int kind);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            case (kind)
               0:       mb[i][j] = (i == j) ? 8'd1 : 8'd0;
               1:       mb[i][j] = 8'd2;
               default: mb[i][j] = 8'(i + 2*j + 1);
            endcase
   endtask

   initial begin
      #20000;
      $display("FAIL global_timeout cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset_feed", 64'({feed_a, feed_b}), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_done", 64'(done), 64'(0));
      chk("reset_ready", 64'(load_ready), 64'(1));
      #1 rst = 1'b0;

      // Basic skew: A = 1..16, B = identity, no gaps.
      set_a(1); set_b(0);
      drive_tile(7'b0001111, 4);
      @(posedge clk); #1 load_valid = 1'b0;
      wait_idle();

      // Load gaps 1,0,0,1,0,1,1 with B all 2s.
      set_a(21); set_b(1);
      drive_tile(7'b1101001, 7);
      @(posedge clk); #1 load_valid = 1'b0;
      wait_idle();

      // Backpressure: junk held valid through FEED/DRAIN/DONE, next tile follows at once.
      set_a(100); set_b(2);
      drive_tile(7'b0001111, 4);
      set_a(200); set_b(0);
      for (int k = 0; k < 4*N-1; k++) begin
         @(posedge clk);
         #1;
         load_valid = 1'b1;
         load_a_row = W'($urandom);
         load_b_col = W'($urandom);
      end
      drive_tile(7'b0001111, 4);
      @(posedge clk); #1 load_valid = 1'b0;
      wait_idle();

      // Asynchronous reset while t=5 is on the feed outputs.
      set_a(50); set_b(0);
      drive_tile(7'b0001111, 4);
      @(posedge clk); #1 load_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midfeed_rst_feed", 64'({feed_a, feed_b}), 64'(0));
      chk("midfeed_rst_busy", 64'(busy), 64'(0));
      chk("midfeed_rst_ready", 64'(load_ready), 64'(1));
      chk("midfeed_rst_done", 64'(done), 64'(0));
      q.delete();
      @(posedge clk);
      #2 rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;

      // Fresh load after reset.
      set_a(70); set_b(2);
      drive_tile(7'b0001111, 4);
      @(posedge clk); #1 load_valid = 1'b0;
      wait_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
